// File: rtl/lane_stripe_ctrl.sv
// Stripes a byte stream onto four 8-bit lanes and presents complete groups downstream.
// Optional group/pad statistics counters are enabled by defining LANE_STRIPE_STATS_EN.
module lane_stripe_ctrl #(
  parameter logic [7:0] PAD_BYTE = 8'hF7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        flush,
  output logic [7:0]  out0,
  output logic [7:0]  out1,
  output logic [7:0]  out2,
  output logic [7:0]  out3,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [3:0]  pad_mask
`ifdef LANE_STRIPE_STATS_EN
  ,
  output logic [15:0] grp_cnt,
  output logic [15:0] pad_cnt
`endif
);

  logic [1:0] ptr_r;
  logic       flush_pend_r;
  logic [7:0] stage_r [3];
  logic [7:0] lane_r [4];
  logic       valid_r;
  logic [3:0] pad_mask_r;

  logic       slot_free_s;
  logic       ready_s;
  logic       accept_s;
  logic       complete_s;
  logic       drain_s;
  logic [1:0] ptr_acc_s;
  logic       pend_s;
  logic       flush_exec_s;
  logic       load_s;
  logic [7:0] view_s [4];
  logic [7:0] lane_nx_s [4];
  logic [3:0] mask_nx_s;
  logic [2:0] pad_num_s;

  // Handshake, pointer advance and flush decision for this cycle
  always_comb begin
    slot_free_s = !valid_r || ready_in;
    ready_s     = !flush_pend_r && ((ptr_r != 2'd3) || slot_free_s);
    accept_s    = valid_in && ready_s;
    complete_s  = accept_s && (ptr_r == 2'd3);
    drain_s     = valid_r && ready_in;
    if (accept_s) begin
      ptr_acc_s = ptr_r + 2'd1;
    end else begin
      ptr_acc_s = ptr_r;
    end
    // A completing accept wraps ptr_acc_s to 0, which consumes a same-cycle flush
    pend_s       = flush_pend_r || (flush && (ptr_acc_s != 2'd0));
    flush_exec_s = pend_s && slot_free_s && !complete_s;
    load_s       = complete_s || flush_exec_s;
    pad_num_s    = 3'd4 - {1'b0, ptr_acc_s};
  end

  // Staging view including a byte accepted this cycle, and the next presented group
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (accept_s && (int'(ptr_r) == i)) begin
        view_s[i] = data_in;
      end else begin
        view_s[i] = stage_r[i];
      end
    end
    view_s[3] = data_in;
    for (int i = 0; i < 4; i++) begin
      if (complete_s || (i < int'(ptr_acc_s))) begin
        lane_nx_s[i] = view_s[i];
        mask_nx_s[i] = 1'b0;
      end else begin
        lane_nx_s[i] = PAD_BYTE;
        mask_nx_s[i] = 1'b1;
      end
    end
  end

  // Pointer, staging lanes and pending-flush state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r        <= 2'd0;
      flush_pend_r <= 1'b0;
      for (int i = 0; i < 3; i++) stage_r[i] <= 8'd0;
    end else begin
      ptr_r        <= flush_exec_s ? 2'd0 : ptr_acc_s;
      flush_pend_r <= pend_s && !flush_exec_s;
      for (int i = 0; i < 3; i++) stage_r[i] <= view_s[i];
    end
  end

  // Presented group: load on completion or flush, retire on drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r    <= 1'b0;
      pad_mask_r <= 4'd0;
      for (int i = 0; i < 4; i++) lane_r[i] <= 8'd0;
    end else if (load_s) begin
      valid_r    <= 1'b1;
      pad_mask_r <= mask_nx_s;
      for (int i = 0; i < 4; i++) lane_r[i] <= lane_nx_s[i];
    end else if (drain_s) begin
      valid_r    <= 1'b0;
    end else begin
      valid_r    <= valid_r;
    end
  end

`ifdef LANE_STRIPE_STATS_EN
  logic [15:0] grp_cnt_r;
  logic [15:0] pad_cnt_r;

  // Emitted-group and inserted-PAD counters, both wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grp_cnt_r <= 16'd0;
      pad_cnt_r <= 16'd0;
    end else if (complete_s) begin
      grp_cnt_r <= grp_cnt_r + 16'd1;
    end else if (flush_exec_s) begin
      grp_cnt_r <= grp_cnt_r + 16'd1;
      pad_cnt_r <= pad_cnt_r + {13'd0, pad_num_s};
    end else begin
      grp_cnt_r <= grp_cnt_r;
    end
  end

  assign grp_cnt = grp_cnt_r;
  assign pad_cnt = pad_cnt_r;
`endif

  assign ready_out = ready_s;
  assign out0      = lane_r[0];
  assign out1      = lane_r[1];
  assign out2      = lane_r[2];
  assign out3      = lane_r[3];
  assign valid_out = valid_r;
  assign pad_mask  = pad_mask_r;

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Directed self-checking bench for lane_stripe_ctrl; define LANE_STRIPE_STATS_EN to also check the counters.
module tb_lane_stripe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        flush = 1'b0;
  logic [7:0]  out0, out1, out2, out3;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [3:0]  pad_mask;
`ifdef LANE_STRIPE_STATS_EN
  logic [15:0] grp_cnt, pad_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] grp;

  lane_stripe_ctrl dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .flush(flush), .out0(out0), .out1(out1),
    .out2(out2), .out3(out3), .valid_out(valid_out), .ready_in(ready_in),
    .pad_mask(pad_mask)
`ifdef LANE_STRIPE_STATS_EN
    , .grp_cnt(grp_cnt), .pad_cnt(pad_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    grp = {out0, out1, out2, out3};
  endtask

  task automatic send(input logic [7:0] b);
    data_in  = b;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    grp = {out0, out1, out2, out3};
    n_chk++; if (grp !== 32'd0) begin n_fail++; $display("FAIL rst_out: got %h expected %h", grp, 32'd0); end
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", valid_out); end
    n_chk++; if (pad_mask !== 4'd0) begin n_fail++; $display("FAIL rst_mask: got %b expected 0000", pad_mask); end
    n_chk++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ready_out); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    ready_in = 1'b1;
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    n_chk++; if (grp !== 32'h01020304) begin n_fail++; $display("FAIL stream_g1: got %h expected %h", grp, 32'h01020304); end
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL stream_v1: got %b expected 1", valid_out); end
    n_chk++; if (pad_mask !== 4'd0) begin n_fail++; $display("FAIL stream_m1: got %b expected 0000", pad_mask); end
    send(8'h05);
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_drain: got %b expected 0", valid_out); end
    n_chk++; if (grp !== 32'h01020304) begin n_fail++; $display("FAIL stream_hold: got %h expected %h", grp, 32'h01020304); end
    send(8'h06); send(8'h07); send(8'h08);
    n_chk++; if (grp !== 32'h05060708) begin n_fail++; $display("FAIL stream_g2: got %h expected %h", grp, 32'h05060708); end
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL stream_v2: got %b expected 1", valid_out); end
    tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got %b expected 0", valid_out); end
  endtask

  task automatic test_flush();
    send(8'hA0); send(8'hA1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++; if (grp !== 32'hA0A1F7F7) begin n_fail++; $display("FAIL flush_data: got %h expected %h", grp, 32'hA0A1F7F7); end
    n_chk++; if (pad_mask !== 4'b1100) begin n_fail++; $display("FAIL flush_mask: got %b expected 1100", pad_mask); end
    n_chk++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b expected 1", valid_out); end
`ifdef LANE_STRIPE_STATS_EN
    n_chk++; if (grp_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_grp: got %0d expected 3", grp_cnt); end
    n_chk++; if (pad_cnt !== 16'd2) begin n_fail++; $display("FAIL stats_pad: got %0d expected 2", pad_cnt); end
`endif
    tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got %b expected 0", valid_out); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b expected 0", valid_out); end
    n_chk++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL flush_empty_rdy: got %b expected 1", ready_out); end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    send(8'h10); send(8'h11); send(8'h12); send(8'h13);
    n_chk++; if (grp !== 32'h10111213) begin n_fail++; $display("FAIL bp_g1: got %h expected %h", grp, 32'h10111213); end
    send(8'h14); send(8'h15); send(8'h16);
    n_chk++; if (grp !== 32'h10111213 || valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_held: got %h/%b expected %h/1", grp, valid_out, 32'h10111213); end
    data_in = 8'h17; valid_in = 1'b1;
    #1;
    n_chk++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got %b expected 0", ready_out); end
    ready_in = 1'b1;
    #1;
    n_chk++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b expected 1", ready_out); end
    tick();
    valid_in = 1'b0;
    n_chk++; if (grp !== 32'h14151617 || valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_g2: got %h/%b expected %h/1", grp, valid_out, 32'h14151617); end
    tick();
    n_chk++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", valid_out); end
  endtask

  task automatic test_flush_pending();
    ready_in = 1'b0;
    send(8'h20); send(8'h21); send(8'h22); send(8'h23);
    send(8'h24);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_chk++; if (grp !== 32'h20212223 || valid_out !== 1'b1) begin n_fail++; $display("FAIL pend_held: got %h/%b expected %h/1", grp, valid_out, 32'h20212223); end
    ready_in = 1'b1;
    #1;
    n_chk++; if (ready_out !== 1'b0) begin n_fail++; $display("FAIL pend_ready: got %b expected 0", ready_out); end
    tick();
    n_chk++; if (grp !== 32'h24F7F7F7 || valid_out !== 1'b1) begin n_fail++; $display("FAIL pend_data: got %h/%b expected %h/1", grp, valid_out, 32'h24F7F7F7); end
    n_chk++; if (pad_mask !== 4'b1110) begin n_fail++; $display("FAIL pend_mask: got %b expected 1110", pad_mask); end
    tick();
    n_chk++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin n_fail++; $display("FAIL pend_after: got %b/%b expected 0/1", valid_out, ready_out); end
  endtask

  task automatic test_flush_on_complete();
    ready_in = 1'b1;
    send(8'h41); send(8'h42); send(8'h43);
    flush = 1'b1;
    send(8'h44);
    flush = 1'b0;
    n_chk++; if (grp !== 32'h41424344 || valid_out !== 1'b1) begin n_fail++; $display("FAIL foc_data: got %h/%b expected %h/1", grp, valid_out, 32'h41424344); end
    n_chk++; if (pad_mask !== 4'd0) begin n_fail++; $display("FAIL foc_mask: got %b expected 0000", pad_mask); end
    tick();
    tick();
    n_chk++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin n_fail++; $display("FAIL foc_nopad: got %b/%b expected 0/1", valid_out, ready_out); end
  endtask

  task automatic test_async_reset();
    ready_in = 1'b0;
    send(8'h30); send(8'h31); send(8'h32); send(8'h33);
    send(8'h51); send(8'h52);
    #2;
    reset = 1'b0;
    #1;
    grp = {out0, out1, out2, out3};
    n_chk++; if (grp !== 32'd0 || valid_out !== 1'b0) begin n_fail++; $display("FAIL arst_out: got %h/%b expected 0/0", grp, valid_out); end
    n_chk++; if (pad_mask !== 4'd0 || ready_out !== 1'b1) begin n_fail++; $display("FAIL arst_misc: got %b/%b expected 0000/1", pad_mask, ready_out); end
    tick();
    reset = 1'b1;
    ready_in = 1'b1;
    send(8'h61); send(8'h62); send(8'h63); send(8'h64);
    n_chk++; if (grp !== 32'h61626364 || valid_out !== 1'b1) begin n_fail++; $display("FAIL arst_clean: got %h/%b expected %h/1", grp, valid_out, 32'h61626364); end
    n_chk++; if (pad_mask !== 4'd0) begin n_fail++; $display("FAIL arst_mask: got %b expected 0000", pad_mask); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush();
    test_backpressure();
    test_flush_pending();
    test_flush_on_complete();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
